// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline stage register with valid/ready handshake, flush and an optional 2-entry skid buffer.
// Head entry drives the M outputs; controls are qualified by out_valid so an empty stage never writes.
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic [DATA_W-1:0] ALUOutE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [REG_AW-1:0] WriteRegE,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic              MemWriteM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [REG_AW-1:0] WriteRegM,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] write_data;
    logic [REG_AW-1:0] write_reg;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKIDS = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  entry_t head;
  entry_t skid;
  entry_t in_entry;
  logic   accept;
  logic   retire;
  logic   load_head_in;
  logic   load_head_skid;
  logic   load_skid;

  assign in_entry = '{reg_write:  RegWriteE,
                      mem_to_reg: MemtoRegE,
                      mem_write:  MemWriteE,
                      alu_out:    ALUOutE,
                      write_data: WriteDataE,
                      write_reg:  WriteRegE};

  assign accept = in_valid & in_ready;
  assign retire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_head_in = 1'b1;
          state_nxt    = FULL;
        end
      end
      FULL: begin
        if (accept && retire) begin
          load_head_in = 1'b1;
        end else if (accept) begin
          // Only reachable with the skid buffer; without it in_ready is low here.
          load_skid = 1'b1;
          state_nxt = SKIDS;
        end else if (retire) begin
          state_nxt = EMPTY;
        end
      end
      SKIDS: begin
        if (retire) begin
          load_head_skid = 1'b1;
          state_nxt      = FULL;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt      = EMPTY;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head_in) begin
        head <= in_entry;
      end else if (load_head_skid) begin
        head <= skid;
      end
      if (load_skid) begin
        skid <= in_entry;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;
      // Registered ready: low only while both entries are held.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= (state_nxt != SKIDS);
        end
      end
      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  always_comb begin
    out_valid  = (state != EMPTY);
    occupancy  = state;
    RegWriteM  = head.reg_write  & out_valid;
    MemtoRegM  = head.mem_to_reg & out_valid;
    MemWriteM  = head.mem_write  & out_valid;
    ALUOutM    = head.alu_out;
    WriteDataM = head.write_data;
    WriteRegM  = head.write_reg;
  end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg: one skid-buffered instance and one single-entry instance
// share the same stimulus; each scenario task checks its own expected values.
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic [31:0] ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE;
  logic        out_ready;

  logic        in_ready, out_valid, RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic [1:0]  occupancy;

  logic        in_ready_z, out_valid_z, RegWriteM_z, MemtoRegM_z, MemWriteM_z;
  logic [31:0] ALUOutM_z, WriteDataM_z;
  logic [4:0]  WriteRegM_z;
  logic [1:0]  occupancy_z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.DATA_W(32), .REG_AW(5), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .out_valid(out_valid), .out_ready(out_ready),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .occupancy(occupancy)
  );

  ex_mem_stage_reg #(.DATA_W(32), .REG_AW(5), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_z),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .out_valid(out_valid_z), .out_ready(out_ready),
    .RegWriteM(RegWriteM_z), .MemtoRegM(MemtoRegM_z), .MemWriteM(MemWriteM_z),
    .ALUOutM(ALUOutM_z), .WriteDataM(WriteDataM_z), .WriteRegM(WriteRegM_z),
    .occupancy(occupancy_z)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] wr,
                       input logic rw, input logic mw);
    in_valid   = v;
    ALUOutE    = alu;
    WriteDataE = alu ^ 32'hFFFF_0000;
    WriteRegE  = wr;
    RegWriteE  = rw;
    MemtoRegE  = 1'b0;
    MemWriteE  = mw;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: out_valid=%b occ=%0d want 0/0", out_valid, occupancy);
    end
    n_checks++;
    if (ALUOutM !== 32'h0 || WriteRegM !== 5'd0 || RegWriteM !== 1'b0) begin
      n_fail++; $display("FAIL reset_data: alu=%h wr=%0d rw=%b want 0", ALUOutM, WriteRegM, RegWriteM);
    end
    n_checks++;
    if (out_valid_z !== 1'b0 || occupancy_z !== 2'd0) begin
      n_fail++; $display("FAIL reset_state_z: out_valid=%b occ=%0d want 0/0", out_valid_z, occupancy_z);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 5'(i + 1), 1'b1, 1'b0);
      step();
      n_checks++;
      if (out_valid !== 1'b1 || ALUOutM !== vals[i] || occupancy > 2'd1) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b alu=%h occ=%0d want 1/%h/<=1", i, out_valid, ALUOutM, occupancy, vals[i]);
      end
    end
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL stream_drain: valid=%b occ=%0d want 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB, 5'd2, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || ALUOutM !== 32'hA) begin
      n_fail++; $display("FAIL bp_full: occ=%0d rdy=%b alu=%h want 2/0/a", occupancy, in_ready, ALUOutM);
    end
    step();
    n_checks++;
    if (ALUOutM !== 32'hA || WriteDataM !== (32'hA ^ 32'hFFFF_0000) || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: alu=%h wd=%h valid=%b want a/ffff000a/1", ALUOutM, WriteDataM, out_valid);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_registered: got %b want 0", in_ready);
    end
    step();
    n_checks++;
    if (ALUOutM !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: alu=%h occ=%0d rdy=%b want b/1/1", ALUOutM, occupancy, in_ready);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL bp_empty: valid=%b occ=%0d want 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h1A, 5'd3, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h1B, 5'd4, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h77, 5'd7, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || MemWriteM !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: valid=%b mw=%b occ=%0d rdy=%b want 0/0/0/1", out_valid, MemWriteM, occupancy, in_ready);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || RegWriteM !== 1'b0) begin
      n_fail++; $display("FAIL flush_dropped: valid=%b rw=%b want 0/0", out_valid, RegWriteM);
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    drive(1'b0, 32'h55, 5'd6, 1'b1, 1'b1);
    step();
    n_checks++;
    if (out_valid !== 1'b0 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
      n_fail++; $display("FAIL bubble_qual: valid=%b rw=%b mw=%b want 0/0/0", out_valid, RegWriteM, MemWriteM);
    end
    drive(1'b1, 32'h56, 5'd6, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || RegWriteM !== 1'b1 || MemWriteM !== 1'b1 || WriteRegM !== 5'd6) begin
      n_fail++;
      $display("FAIL bubble_real: valid=%b rw=%b mw=%b wr=%0d want 1/1/1/6", out_valid, RegWriteM, MemWriteM, WriteRegM);
    end
    step();
  endtask

  task automatic test_no_skid();
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h5, 5'd5, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (out_valid_z !== 1'b1 || WriteRegM_z !== 5'd5 || in_ready_z !== 1'b0 || occupancy_z !== 2'd1) begin
      n_fail++;
      $display("FAIL noskid_stall: valid=%b wr=%0d rdy=%b occ=%0d want 1/5/0/1", out_valid_z, WriteRegM_z, in_ready_z, occupancy_z);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready_z !== 1'b1) begin
      n_fail++; $display("FAIL noskid_comb_ready: got %b want 1", in_ready_z);
    end
    drive(1'b1, 32'h9, 5'd9, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (out_valid_z !== 1'b1 || WriteRegM_z !== 5'd9 || occupancy_z !== 2'd1) begin
      n_fail++; $display("FAIL noskid_reload: valid=%b wr=%0d occ=%0d want 1/9/1", out_valid_z, WriteRegM_z, occupancy_z);
    end
    step();
    n_checks++;
    if (out_valid_z !== 1'b0 || occupancy_z !== 2'd0) begin
      n_fail++; $display("FAIL noskid_drain: valid=%b occ=%0d want 0/0", out_valid_z, occupancy_z);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'hC1, 5'd1, 1'b1, 1'b1);
    step();
    drive(1'b1, 32'hC2, 5'd2, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    n_checks++;
    if (occupancy !== 2'd2) begin
      n_fail++; $display("FAIL areset_setup: occ=%0d want 2", occupancy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || MemWriteM !== 1'b0) begin
      n_fail++; $display("FAIL areset_immediate: valid=%b occ=%0d mw=%b want 0/0/0", out_valid, occupancy, MemWriteM);
    end
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL areset_after: valid=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_no_skid();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
